// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: core-side load/store bridge to a big-endian external data bus.
// Takes one little-endian, right-aligned byte/half/word access at a time, turns it
// into a word-aligned bus beat with byte enables, and formats load data on return.
// Optional build macro: LSU_BUS_TIMEOUT_EN adds an abort counter on REQ/WAIT.
module lsu_bus_bridge #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            bus_valid,
   input  logic            bus_ready,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;

   logic              req_illegal;
   logic [3:0]        le_mask;
   logic [3:0]        lane_mask;
   logic [XLEN-1:0]   le_wdata;
   logic [3:0]        store_be;
   logic [XLEN-1:0]   store_wdata;
   logic [XLEN-1:0]   load_le;
   logic [XLEN-1:0]   load_data;

   // Lane k of the little-endian view sits at the big-endian position 3-k.
   function automatic logic [31:0] swap_bytes(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

`ifdef LSU_BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Decode the incoming request: legality, byte enables and store lane data.
   always_comb begin
      req_illegal = 1'b0;
      le_mask     = 4'b1111;
      le_wdata    = req_wdata;
      case (req_size)
         2'b00: begin
            le_mask  = 4'b0001;
            le_wdata = {24'b0, req_wdata[7:0]};
         end
         2'b01: begin
            le_mask     = 4'b0011;
            le_wdata    = {16'b0, req_wdata[15:0]};
            req_illegal = req_addr[0];
         end
         2'b10: begin
            req_illegal = (req_addr[1:0] != 2'b00);
         end
         default: begin
            req_illegal = 1'b1;
         end
      endcase
      lane_mask   = le_mask << req_addr[1:0];
      store_be    = {lane_mask[0], lane_mask[1], lane_mask[2], lane_mask[3]};
      store_wdata = swap_bytes(le_wdata << {req_addr[1:0], 3'b000});
   end

   // Pull the addressed bytes out of the big-endian read word and extend them.
   always_comb begin
      load_le = swap_bytes(bus_rdata) >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'b00:   load_data = {{24{~unsigned_q & load_le[7]}}, load_le[7:0]};
         2'b01:   load_data = {{16{~unsigned_q & load_le[15]}}, load_le[15:0]};
         default: load_data = load_le;
      endcase
   end

   // Next-state logic: capture in IDLE, handshake in REQ, collect in WAIT, pulse in RESP.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               addr_d     = req_addr;
               be_d       = store_be;
               wdata_d    = req_we ? store_wdata : '0;
               err_d      = req_illegal;
               rdata_d    = '0;
               state_d    = req_illegal ? S_RESP : S_REQ;
`ifdef LSU_BUS_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         S_REQ: begin
            if (bus_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus_rvalid) begin
               err_d   = bus_err;
               rdata_d = (we_q || bus_err) ? '0 : load_data;
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef LSU_BUS_TIMEOUT_EN
      if (state_q == S_REQ || state_q == S_WAIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST && !(state_q == S_WAIT && bus_rvalid)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
         end
      end
`endif
   end

   // State and request registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         be_q       <= 4'b0000;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
`ifdef LSU_BUS_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
`ifdef LSU_BUS_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign bus_valid  = (state_q == S_REQ);
   assign bus_we     = we_q;
   assign bus_addr   = {addr_q[XLEN-1:2], 2'b00};
   assign bus_be     = be_q;
   assign bus_wdata  = wdata_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = (state_q == S_RESP) & err_q;
   assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;

endmodule
